// File: rtl/halt_dump_if.sv
`default_nettype none
// ============================================================================
//  Module   : halt_dump_if
//  Purpose  : Groups the register-dump stream and the debug read port into
//             one bundle. The master side is the halt/dump unit.
//  Signals  : dump_valid / dump_ready - beat handshake
//             dump_idx / dump_data    - beat index and register value
//             rf_rd_addr / rf_rd_data - asynchronous debug read of the RF
//  Revision : 1.0 - initial release
// ============================================================================
interface halt_dump_if #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic             dump_valid;
  logic             dump_ready;
  logic [IDX_W-1:0] dump_idx;
  logic [XLEN-1:0]  dump_data;
  logic [IDX_W-1:0] rf_rd_addr;
  logic [XLEN-1:0]  rf_rd_data;

  modport master (
    output dump_valid, dump_idx, dump_data, rf_rd_addr,
    input  dump_ready, rf_rd_data
  );

  modport slave (
    input  dump_valid, dump_idx, dump_data, rf_rd_addr,
    output dump_ready, rf_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/halt_dump_unit.sv
`default_nettype none
// ============================================================================
//  Module   : halt_dump_unit
//  Purpose  : On a halt request, freezes the pipeline, waits DRAIN_CYCLES for
//             in-flight writebacks, streams every architectural register over
//             a valid/ready port, then raises is_halted. Also keeps the
//             saturating count of cycles spent running.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             halt_req          - halt request, sampled only while running
//             stall_pipe        - freezes fetch/decode and RF writes
//             dif (master)      - dump stream + RF debug read port
//             cycle_count       - cycles spent in RUN since reset
//             is_halted         - dump complete, held until reset
//  Config   : HALT_DUMP_EN - when defined, the register dump is built in;
//             when undefined, DRAIN goes straight to DONE and the dump
//             outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module halt_dump_unit #(
  parameter int NUM_REGS     = 32,
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt_req,
  output logic        stall_pipe,
  halt_dump_if.master dif,
  output logic [31:0] cycle_count,
  output logic        is_halted
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [31:0]      CC_MAX   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
`ifdef HALT_DUMP_EN
    ST_DUMP  = 2'd2,
`endif
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic             stall_q;
  logic             halted_q;
  logic [31:0]      cycle_count_q;
  logic [CNT_W-1:0] drain_cnt_q;

`ifdef HALT_DUMP_EN
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic             dump_valid_q;
  logic [IDX_W-1:0] dump_idx_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      stall_q       <= 1'b0;
      halted_q      <= 1'b0;
      cycle_count_q <= '0;
      drain_cnt_q   <= '0;
`ifdef HALT_DUMP_EN
      dump_valid_q  <= 1'b0;
      dump_idx_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_RUN: begin
          // The cycle that samples halt_req still counts as a running cycle.
          if (cycle_count_q != CC_MAX) begin
            cycle_count_q <= cycle_count_q + 32'd1;
          end
          if (halt_req) begin
            state_q     <= ST_DRAIN;
            stall_q     <= 1'b1;
            drain_cnt_q <= '0;
          end
        end

        ST_DRAIN: begin
          // Edges t+1 .. t+DRAIN_CYCLES are spent here; the last one leaves.
          if (drain_cnt_q == LAST_CNT) begin
`ifdef HALT_DUMP_EN
            state_q      <= ST_DUMP;
            dump_valid_q <= 1'b1;
            dump_idx_q   <= '0;
`else
            state_q      <= ST_DONE;
            halted_q     <= 1'b1;
`endif
          end else begin
            drain_cnt_q <= drain_cnt_q + CNT_W'(1);
          end
        end

`ifdef HALT_DUMP_EN
        ST_DUMP: begin
          // dump_valid is always high here, so ready alone marks a transfer.
          if (dif.dump_ready) begin
            if (dump_idx_q == LAST_IDX) begin
              state_q      <= ST_DONE;
              dump_valid_q <= 1'b0;
              halted_q     <= 1'b1;
            end else begin
              dump_idx_q <= dump_idx_q + IDX_W'(1);
            end
          end
        end
`endif

        ST_DONE: begin
          // Terminal: only reset leaves this state.
        end

        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign stall_pipe  = stall_q;
  assign is_halted   = halted_q;
  assign cycle_count = cycle_count_q;

`ifdef HALT_DUMP_EN
  // Read data is stable during DUMP because all RF writes are stalled.
  // Outside DUMP the data is masked so that idle outputs read as zero.
  assign dif.dump_valid = dump_valid_q;
  assign dif.dump_idx   = dump_idx_q;
  assign dif.rf_rd_addr = dump_idx_q;
  assign dif.dump_data  = dump_valid_q ? dif.rf_rd_data : {XLEN{1'b0}};
`else
  logic unused_dump_inputs;
  assign unused_dump_inputs = dif.dump_ready ^ (^dif.rf_rd_data);

  assign dif.dump_valid = 1'b0;
  assign dif.dump_idx   = '0;
  assign dif.rf_rd_addr = '0;
  assign dif.dump_data  = {XLEN{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_halt_dump_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_halt_dump_unit
//  Purpose  : Self-checking bench for halt_dump_unit. A behavioural model
//             tracks the expected running-cycle count, the expected beat
//             order and the halt latency (drain + beats + stall cycles).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_halt_dump_unit;

  localparam int N  = 32;
  localparam int XW = 32;
  localparam int D  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt_req;
  logic        stall_pipe;
  logic [31:0] cycle_count;
  logic        is_halted;

  halt_dump_if #(.NUM_REGS(N), .XLEN(XW)) dif ();

  halt_dump_unit #(
    .NUM_REGS     (N),
    .XLEN         (XW),
    .DRAIN_CYCLES (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .halt_req    (halt_req),
    .stall_pipe  (stall_pipe),
    .dif         (dif),
    .cycle_count (cycle_count),
    .is_halted   (is_halted)
  );

  always #5 clk = ~clk;

  // Register-file model: asynchronous read.
  logic [XW-1:0] regs [N];
  always_comb dif.rf_rd_data = regs[dif.rf_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cc;
  bit          ab;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_regs(input bit pattern);
    for (int i = 0; i < N; i++)
      regs[i] = pattern ? (32'hA000_0000 + 32'(i)) : $urandom;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_stall"},  64'(stall_pipe),     64'd0);
    chk({tag, "_valid"},  64'(dif.dump_valid), 64'd0);
    chk({tag, "_idx"},    64'(dif.dump_idx),   64'd0);
    chk({tag, "_addr"},   64'(dif.rf_rd_addr), 64'd0);
    chk({tag, "_data"},   64'(dif.dump_data),  64'd0);
    chk({tag, "_cc"},     64'(cycle_count),    64'd0);
    chk({tag, "_halted"}, 64'(is_halted),      64'd0);
  endtask

  // Two reset edges; halt_req is raised on the last one and must be ignored.
  task automatic apply_reset();
    reset = 1'b1;
    halt_req = 1'b0;
    dif.dump_ready = 1'b0;
    step();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    reset = 1'b0;
    exp_cc = 32'd0;
    check_zero_outputs("reset");
  endtask

  // mode 0: ready always 1; mode 1: ready 1,0,0 repeating; mode 2: random.
  task automatic run_scenario(input int pre, input int mode, input int reset_beat,
                              output bit aborted);
    int t_halt;
    int stalls;
    int idx;
    int guard;
    bit rdy;
    aborted = 1'b0;
    stalls = 0;
    idx = 0;
    guard = 0;
    rdy = 1'b0;

    for (int i = 0; i < pre; i++) begin
      step();
      exp_cc = sat_inc(exp_cc);
      chk("run_cc",    64'(cycle_count),    64'(exp_cc));
      chk("run_stall", 64'(stall_pipe),     64'd0);
      chk("run_valid", 64'(dif.dump_valid), 64'd0);
    end

    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    exp_cc = sat_inc(exp_cc);
    t_halt = cyc;
    chk("halt_cc", 64'(cycle_count), 64'(exp_cc));

    // Drain window; random halt_req / dump_ready must have no effect.
    for (int k = 0; k < D; k++) begin
      chk("drain_stall",  64'(stall_pipe),     64'd1);
      chk("drain_valid",  64'(dif.dump_valid), 64'd0);
      chk("drain_halted", 64'(is_halted),      64'd0);
      chk("drain_cc",     64'(cycle_count),    64'(exp_cc));
      halt_req = 1'($urandom_range(1, 0));
      dif.dump_ready = 1'($urandom_range(1, 0));
      step();
    end
    halt_req = 1'b0;

`ifdef HALT_DUMP_EN
    while (idx < N && guard < 2000) begin
      chk("dump_valid",  64'(dif.dump_valid), 64'd1);
      chk("dump_idx",    64'(dif.dump_idx),   64'(idx));
      chk("dump_addr",   64'(dif.rf_rd_addr), 64'(idx));
      chk("dump_data",   64'(dif.dump_data),  64'(regs[idx]));
      chk("dump_stall",  64'(stall_pipe),     64'd1);
      chk("dump_halted", 64'(is_halted),      64'd0);
      chk("dump_cc",     64'(cycle_count),    64'(exp_cc));
      if (idx == reset_beat) begin
        reset = 1'b1;
        halt_req = 1'b0;
        dif.dump_ready = 1'b1;
        step();
        reset = 1'b0;
        dif.dump_ready = 1'b0;
        exp_cc = 32'd0;
        check_zero_outputs("midreset");
        aborted = 1'b1;
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 3 == 0);
        default: rdy = 1'($urandom_range(1, 0));
      endcase
      dif.dump_ready = rdy;
      halt_req = 1'($urandom_range(1, 0));
      step();
      if (rdy) idx++;
      else     stalls++;
      guard++;
    end
    halt_req = 1'b0;
    chk("dump_beats", 64'(idx), 64'(N));
    chk("halt_latency", 64'(cyc - t_halt), 64'(D + N + stalls));
`else
    if (reset_beat >= 0) aborted = 1'b0;
    chk("halt_latency", 64'(cyc - t_halt), 64'(D));
    chk("off_idx",  64'(dif.dump_idx),   64'd0);
    chk("off_addr", 64'(dif.rf_rd_addr), 64'd0);
    chk("off_data", 64'(dif.dump_data),  64'd0);
`endif
    chk("done_halted", 64'(is_halted),      64'd1);
    chk("done_valid",  64'(dif.dump_valid), 64'd0);
    chk("done_stall",  64'(stall_pipe),     64'd1);
    chk("done_cc",     64'(cycle_count),    64'(exp_cc));

    for (int k = 0; k < 3; k++) begin
      halt_req = 1'($urandom_range(1, 0));
      dif.dump_ready = 1'($urandom_range(1, 0));
      step();
      chk("hold_halted", 64'(is_halted),      64'd1);
      chk("hold_stall",  64'(stall_pipe),     64'd1);
      chk("hold_valid",  64'(dif.dump_valid), 64'd0);
      chk("hold_cc",     64'(cycle_count),    64'(exp_cc));
    end
    halt_req = 1'b0;
    dif.dump_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    halt_req = 1'b0;
    dif.dump_ready = 1'b0;
    exp_cc = 32'd0;
    ab = 1'b0;

    // Basic halt: 10 running cycles, halt on the 11th, ready held high.
    fill_regs(1'b1);
    apply_reset();
    run_scenario(10, 0, -1, ab);

    // Backpressure with a 1,0,0 ready pattern.
    fill_regs(1'b0);
    apply_reset();
    run_scenario(5 + int'($urandom_range(9, 0)), 1, -1, ab);

    // Random backpressure.
    fill_regs(1'b0);
    apply_reset();
    run_scenario(int'($urandom_range(20, 1)), 2, -1, ab);

    // Reset at beat 12, then a fresh halt must dump again from index 0.
    fill_regs(1'b0);
    apply_reset();
    run_scenario(7, 0, 12, ab);
    if (!ab) apply_reset();
    fill_regs(1'b0);
    run_scenario(4, 2, -1, ab);

    // Saturation of the running-cycle counter.
    apply_reset();
    force dut.cycle_count_q = 32'hFFFF_FFFD;
    #1;
    release dut.cycle_count_q;
    exp_cc = 32'hFFFF_FFFD;
    chk("sat_start", 64'(cycle_count), 64'(exp_cc));
    for (int i = 0; i < 5; i++) begin
      step();
      exp_cc = sat_inc(exp_cc);
      chk("sat_cc", 64'(cycle_count), 64'(exp_cc));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/halt_dump_unit.md
# halt_dump_unit

- Sits inside the CPU between the pipeline control logic and the register file.
- On a halt request (ECALL with x17 == 10, decoded upstream), it freezes the pipeline, waits a fixed number of cycles for in-flight writebacks to finish, then streams all architectural registers out over a valid/ready port.
- When the stream ends it asserts `is_halted`.
- It also keeps the committed-cycle count that the simulation harness reports.

## Interface
Parameters:
- `NUM_REGS`, default 32: number of registers streamed; also sets the `dump_idx` width (5 bits at the default).
- `XLEN`, default 32: data width.
- `DRAIN_CYCLES`, default 4: cycles to wait between halt acceptance and the dump. Must be ≥ 1.

Ports:
- `clk`  in  1: single clock; everything is rising-edge.
- `reset`  in  1: synchronous, active-high; sampled on the `clk` rising edge.
- `halt_req`  in  1: halt request from the ID/EX stage. Sampled only in RUN.
- `stall_pipe`  out  1: freezes fetch/decode and all register file writes.
- `rf_rd_addr`  out  $clog2(NUM_REGS): debug read address into the register file (asynchronous read).
- `rf_rd_data`  in  XLEN: debug read data from the register file.
- `dump_valid`  out  1: a dump beat is offered.
- `dump_ready`  in  1: the consumer accepts the beat.
- `dump_idx`  out  $clog2(NUM_REGS): index of the current beat.
- `dump_data`  out  XLEN: value of the register at `dump_idx`.
- `cycle_count`  out  32: cycles spent in RUN since reset.
- `is_halted`  out  1: dump complete; held high until reset.

## Operation
States and transitions:
- RUN → DRAIN when `halt_req` = 1.
- DRAIN → DUMP once `DRAIN_CYCLES` cycles have elapsed.
- DUMP → DONE on the handshake of the last beat.
- DONE is terminal; only `reset` leaves it.

Reset:
- `reset` forces RUN from any state, including mid-DRAIN and mid-DUMP.
- Reset values: all outputs 0, internal drain counter 0, index 0.

RUN:
- `cycle_count` increments by 1 every cycle, including the cycle in which `halt_req` is sampled.
- `cycle_count` saturates at 32'hFFFF_FFFF.
- `stall_pipe` = 0 and `dump_valid` = 0.

DRAIN:
- `stall_pipe` = 1.
- `cycle_count` is frozen.
- The drain counter counts `DRAIN_CYCLES` cycles.

DUMP:
- `stall_pipe` = 1 and `dump_valid` = 1.
- `rf_rd_addr` = `dump_idx`, and `dump_data` = `rf_rd_data` (combinational pass-through). This is stable because all register file writes are stalled.
- A beat is transferred when `dump_valid` and `dump_ready` are both 1 on a rising edge. On a transfer, `dump_idx` increments.
- A transfer at `dump_idx` = NUM_REGS−1 ends the dump (DUMP → DONE); the index does not wrap.
- With `dump_ready` = 0, `dump_valid`, `dump_idx` and `dump_data` must hold unchanged. There is no timeout.

DONE:
- `is_halted` = 1, `stall_pipe` = 1, `dump_valid` = 0.
- `cycle_count` stays frozen.

Ignored inputs:
- `halt_req` is ignored in DRAIN, DUMP and DONE.
- `dump_ready` is ignored outside DUMP.

Register 0 is streamed as read from the register file; no forced zero is applied here.

## Timing
Take `halt_req` = 1 sampled at edge t, while in RUN:
- Edge t: `cycle_count` takes its final value N, where the first RUN cycle after reset release yields 1.
- Cycles t+1 … t+DRAIN_CYCLES: state is DRAIN. `stall_pipe` is first high in cycle t+1 (registered output).
- Cycle t+DRAIN_CYCLES+1: `dump_valid` first high, `dump_idx` = 0.
- If `dump_ready` is held at 1: one beat per cycle, last beat (idx NUM_REGS−1) at t+DRAIN_CYCLES+NUM_REGS, and `is_halted` high from t+DRAIN_CYCLES+NUM_REGS+1.
- Each cycle with `dump_ready` = 0 during DUMP adds exactly 1 cycle to that latency.
- `halt_req` asserted in the same cycle that `reset` deasserts is ignored: reset has priority, and sampling starts at the next edge.

## Configuration
- `HALT_DUMP_EN` defined: behaviour exactly as above.
- Not defined:
  - The DUMP state is compiled out; DRAIN goes directly to DONE.
  - `is_halted` is high from t+DRAIN_CYCLES+1.
  - `dump_valid`, `dump_idx`, `dump_data` and `rf_rd_addr` are tied to 0, and `dump_ready` / `rf_rd_data` are unused.
  - `cycle_count` and `stall_pipe` behave identically.

## Test plan
- **Basic halt and dump.** Reset 2 cycles, run 10 RUN cycles, pulse `halt_req`; register model returns 32'hA000_0000 + idx; `dump_ready` = 1. Expect `cycle_count` = 11, `stall_pipe` high 1 cycle later, beats 0..31 with matching data over 32 consecutive cycles, and `is_halted` 37 cycles after the `halt_req` edge (DRAIN_CYCLES = 4).
- **Backpressure.** Toggle `dump_ready` 1,0,0,1… Expect `dump_idx`/`dump_data` held during stalls, no skipped or duplicated index, and `is_halted` delayed by exactly the number of stall cycles.
- **Extra halt requests.** Assert `halt_req` again in DRAIN and in DUMP. Expect no restart, no `cycle_count` change, and the drain length unchanged.
- **Reset mid-dump.** Assert `reset` at beat 12. Expect the next cycle to show all outputs 0 and state RUN; a second halt re-dumps from idx 0.
- **Counter saturation.** Force `cycle_count` near 32'hFFFF_FFFE and run 5 cycles. Expect it to hold at 32'hFFFF_FFFF.
- **Macro off.** Build without `HALT_DUMP_EN`. Expect `is_halted` at t+5 with `dump_valid` never asserted.
